// File: rtl/conv_zseq_fsm.sv
// Convolution sequencer: walks k over all output samples and i over X, reads X/Y,
// accumulates x[i]*y[k-i] and writes one z sample per k to the Z memory.
module conv_zseq_fsm #(
  parameter int DATA_W = 8,
  parameter int Z_W    = 32
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              start_i,
  input  logic [5:0]        sizeX_i,
  input  logic [5:0]        sizeY_i,
  input  logic [5:0]        zind_nxt_i,
  output logic [5:0]        zind_o,
  output logic [4:0]        memX_addr_o,
  output logic [4:0]        memY_addr_o,
  input  logic [DATA_W-1:0] memX_data_i,
  input  logic [DATA_W-1:0] memY_data_i,
  output logic [5:0]        memZ_addr_o,
  output logic [Z_W-1:0]    memZ_data_o,
  output logic              memZ_we_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int ACC_W  = 2*DATA_W + 5;
  localparam int PROD_W = 2*DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ADDR, S_MAC, S_INC, S_WRITE, S_NEXTZ, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         zind_q, zind_d;
  logic [5:0]         i_q, i_d;
  logic [5:0]         size_x_q, size_x_d;
  logic [5:0]         size_y_q, size_y_d;
  logic [ACC_W-1:0]   acc_q, acc_d;

  logic [6:0]         diff;
  logic               d_valid;
  logic               last_z;
  logic [5:0]         i_inc;
  logic [PROD_W-1:0]  prod;
  logic               addr_en;

  // d = k - i in 7-bit two's complement; bit 6 set means i ran past k
  assign diff    = {1'b0, zind_q} - {1'b0, i_q};
  assign d_valid = !diff[6] && (diff < {1'b0, size_y_q});
  assign last_z  = ({1'b0, zind_q} == ({1'b0, size_x_q} + {1'b0, size_y_q} - 7'd2));
  assign i_inc   = i_q + 6'd1;
  assign prod    = {{DATA_W{1'b0}}, memX_data_i} * {{DATA_W{1'b0}}, memY_data_i};

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q  <= S_IDLE;
      zind_q   <= '0;
      i_q      <= '0;
      size_x_q <= '0;
      size_y_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      zind_q   <= zind_d;
      i_q      <= i_d;
      size_x_q <= size_x_d;
      size_y_q <= size_y_d;
      acc_q    <= acc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    zind_d   = zind_q;
    i_d      = i_q;
    size_x_d = size_x_q;
    size_y_d = size_y_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          size_x_d = sizeX_i;
          size_y_d = sizeY_i;
          zind_d   = '0;
          if (sizeX_i == 6'd0 || sizeY_i == 6'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_CLR: begin
        acc_d   = '0;
        i_d     = '0;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        state_d = d_valid ? S_MAC : S_INC;
      end
      S_MAC: begin
        // read data arrives here, one cycle after the ADDR-cycle addresses
        acc_d   = acc_q + {{(ACC_W-PROD_W){1'b0}}, prod};
        state_d = S_INC;
      end
      S_INC: begin
        i_d     = i_inc;
        state_d = (i_inc == size_x_q) ? S_WRITE : S_ADDR;
      end
      S_WRITE: begin
        state_d = S_NEXTZ;
      end
      S_NEXTZ: begin
        if (last_z) begin
          state_d = S_DONE;
        end else begin
          zind_d  = zind_nxt_i;
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Addresses are only meaningful for a valid (i, k-i) pair; held through MAC
  assign addr_en     = ((state_q == S_ADDR) || (state_q == S_MAC)) && d_valid;
  assign memX_addr_o = addr_en ? i_q[4:0]  : 5'd0;
  assign memY_addr_o = addr_en ? diff[4:0] : 5'd0;

  assign zind_o      = zind_q;
  assign memZ_addr_o = zind_q;
  assign memZ_we_o   = (state_q == S_WRITE);
  assign memZ_data_o = (state_q == S_WRITE) ? Z_W'(acc_q) : '0;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: doc/conv_zseq_fsm.md
# conv_zseq_fsm

Sequencer for the convolution core: z[k] = Σ x[i]·y[k−i] over all valid i, for k = 0 … sizeX+sizeY−2. It owns the 6-bit z-index register, driving `zind_o` to the z-index increment adder and loading that adder's result back on each output step. It also drives the X/Y memory read addresses, accumulates the products, and writes each finished z sample to the Z memory.

## Interface
- `DATA_W`, 8, width of X and Y samples (unsigned)
- `Z_W`, 32, width of Z memory data (accumulator zero-extended)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_a`  in  1  asynchronous, active-low reset
- `start_i`  in  1  start request, sampled only in IDLE
- `sizeX_i`  in  6  X length, 1..32
- `sizeY_i`  in  6  Y length, 1..32
- `zind_nxt_i`  in  6  from z-index adder, equals `zind_o`+1
- `zind_o`  out  6  current z index (registered)
- `memX_addr_o`  out  5  X read address (= i)
- `memY_addr_o`  out  5  Y read address (= k−i)
- `memX_data_i`  in  DATA_W  X read data, valid one cycle after address
- `memY_data_i`  in  DATA_W  Y read data, valid one cycle after address
- `memZ_addr_o`  out  6  Z write address (= `zind_o`)
- `memZ_data_o`  out  Z_W  Z write data (accumulator)
- `memZ_we_o`  out  1  Z write strobe, one cycle per z
- `busy_o`  out  1  high in every state except IDLE
- `done_o`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLR, ADDR, MAC, INC, WRITE, NEXTZ, DONE. All outputs are decoded from registered state/counters (Moore).
- IDLE: `start_i`=1 with both sizes ≠0 → CLR. Also latch sizeX/sizeY and set zind=0. With either size =0 → DONE directly, no writes. `start_i` outside IDLE is ignored.
- CLR: acc←0, i←0 → ADDR.
- ADDR: d = k−i, evaluated as 7-bit two's complement. Valid iff 0 ≤ d < sizeY.
  - Valid: addresses driven → MAC.
  - Invalid: no accumulate → INC.
- MAC: acc ← acc + X·Y. Product width is 2·DATA_W, and acc is 2·DATA_W+5 bits, so there is no overflow. Then → INC.
- INC: i←i+1. If the new i = sizeX → WRITE, else → ADDR.
- WRITE: `memZ_we_o`=1, addr=zind, data=acc zero-extended to Z_W → NEXTZ.
- NEXTZ:
  - If zind = sizeX+sizeY−2 → DONE.
  - Else zind ← `zind_nxt_i` → CLR.
- DONE: `done_o`=1 for exactly one cycle → IDLE.
- Max zind = 62, so the 6-bit index never wraps. Sizes >32 are out of contract.
- Reset, including mid-operation: state=IDLE and every output 0 (`zind_o`, addresses, `memZ_data_o`, `memZ_we_o`, `busy_o`, `done_o`). Internal acc/i/sizes are also 0. No write is issued after reset asserts.

## Timing
- Start accepted at edge E0 → CLR in cycle 1.
- Cycles per z:
  - CLR: 1
  - each valid i: 3 (ADDR, MAC, INC)
  - each invalid i: 2 (ADDR, INC)
  - WRITE: 1
  - NEXTZ: 1
- The memory read latency of 1 cycle is consumed by the ADDR→MAC step. Addresses are held stable through MAC.
- `memZ_we_o` is high only in WRITE, with `memZ_addr_o`/`memZ_data_o` valid in that same cycle.
- `done_o` rises the cycle after the final NEXTZ. `busy_o` falls on the following cycle (IDLE).
- `zind_o` changes only in IDLE (→0) and NEXTZ.

## Test plan
- sizeX=1, sizeY=1, x={7}, y={9}:
  - one write, addr 0, data 63, `memZ_we_o` in cycle 5
  - `done_o` in cycle 7
- sizeX=3, x={1,2,3}; sizeY=2, y={4,5}:
  - writes addr0=4, addr1=13, addr2=22, addr3=15 (sizes 3+2 → 4 outputs)
  - `done_o` in cycle 43
- sizeX=32, sizeY=32, all samples 255:
  - 63 writes; the addr31 value is 2,080,800 (32·255²)
  - last zind=62, no wrap
- sizeX=0, any sizeY, start=1: no `memZ_we_o`; `done_o` pulses 1 cycle after start; `busy_o` high one cycle.
- Assert `rst_a` low during MAC of z=1 (sizeX=3, sizeY=2 case):
  - all outputs 0 immediately (asynchronously), no further writes
  - a new start after release reruns cleanly from z=0
- `start_i` held high through the whole sizeX=3, sizeY=2 run:
  - ignored while busy
  - a new run begins exactly one cycle after `done_o` (IDLE sampled)
